// File: rtl/seq_decoder_if.sv
// Handshake bundle for seq_decoder: select/enable/mode beats in, one-hot beats out.
// slave is the decoder side, master is the select source plus one-hot consumer.
interface seq_decoder_if #(
    parameter int OUTS = 4
);
    localparam int SW = $clog2(OUTS);

    logic            e;
    logic            mode;
    logic [SW-1:0]   s;
    logic            in_valid;
    logic            in_ready;
    logic [OUTS-1:0] y;
    logic            out_valid;
    logic            out_ready;
    logic            err;

    modport slave (
        input  e, mode, s, in_valid, out_ready,
        output in_ready, y, out_valid, err
    );

    modport master (
        output e, mode, s, in_valid, out_ready,
        input  in_ready, y, out_valid, err
    );
endinterface

// File: rtl/seq_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and an autonomous scan walk.
// Define SEQ_DECODER_RANGE_CHK_EN to flag direct selects >= OUTS on err.
module seq_decoder #(
    parameter int OUTS = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_decoder_if.slave bus
);
    localparam int SW = $clog2(OUTS);
    localparam logic [OUTS-1:0] ONE      = OUTS'(1);
    localparam logic [SW-1:0]   IDX_LAST = SW'(OUTS - 1);

    typedef enum logic {
        ST_DIRECT,
        ST_SCAN
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   idx_q, idx_d;
    logic [OUTS-1:0] y_q, y_d;
    logic            out_valid_q, out_valid_d;
    logic            reg_free;

`ifdef SEQ_DECODER_RANGE_CHK_EN
    localparam logic [SW:0] OUTS_W = (SW + 1)'(OUTS);
    logic err_q, err_d;
`endif

    // The output register can take a new beat when empty or being drained this cycle.
    assign reg_free     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state_q == ST_DIRECT) && reg_free;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        idx_d       = idx_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_DECODER_RANGE_CHK_EN
        err_d       = err_q;
`endif

        if (state_q == ST_SCAN) begin
            if (bus.e && reg_free) begin
                y_d         = ONE << idx_q;
                out_valid_d = 1'b1;
                idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + SW'(1);
`ifdef SEQ_DECODER_RANGE_CHK_EN
                err_d       = 1'b0;
`endif
            end else if (reg_free) begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (bus.in_valid && reg_free) begin
                // Selects past OUTS shift the single bit out of range, leaving y all-zero.
                y_d         = bus.e ? (ONE << bus.s) : '0;
                out_valid_d = 1'b1;
`ifdef SEQ_DECODER_RANGE_CHK_EN
                err_d       = ({1'b0, bus.s} >= OUTS_W);
`endif
            end else if (reg_free) begin
                out_valid_d = 1'b0;
            end
        end

        // A held beat pins the mode so it can never be re-interpreted mid-stall.
        if (reg_free) begin
            state_d = bus.mode ? ST_SCAN : ST_DIRECT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DIRECT;
            idx_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef SEQ_DECODER_RANGE_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_DECODER_RANGE_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
`ifdef SEQ_DECODER_RANGE_CHK_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: directed scenarios on OUTS=4 and OUTS=6 instances
// plus a randomized run of the OUTS=6 instance against a behavioural model.
module tb_seq_decoder;
`ifdef SEQ_DECODER_RANGE_CHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_decoder_if #(.OUTS(4)) if4 ();
    seq_decoder_if #(.OUTS(6)) if6 ();

    seq_decoder #(.OUTS(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    seq_decoder #(.OUTS(6)) u6 (.clk(clk), .rst(rst), .bus(if6.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if4.e = 1'b0; if4.mode = 1'b0; if4.s = '0; if4.in_valid = 1'b0; if4.out_ready = 1'b0;
        if6.e = 1'b0; if6.mode = 1'b0; if6.s = '0; if6.in_valid = 1'b0; if6.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (if4.y !== 4'b0000) begin errors++; $display("FAIL rst_y got %b want 0000", if4.y); end
        if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_ov got %b want 0", if4.out_valid); end
        if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ir got %b want 1", if4.in_ready); end
        if (if4.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", if4.err); end

        // Move idx away from 0, then hold a direct beat s=2 under backpressure.
        if4.mode = 1'b1; if4.e = 1'b1; if4.out_ready = 1'b1;
        step(); step(); step();
        if4.mode = 1'b0;
        step();
        if4.in_valid = 1'b1; if4.s = 2'd2;
        step();
        if4.in_valid = 1'b0; if4.out_ready = 1'b0;
        step();
        checks++;
        if (if4.y !== 4'b0100 || if4.out_valid !== 1'b1) begin
            errors++; $display("FAIL pre_rst_hold got y=%b ov=%b want y=0100 ov=1", if4.y, if4.out_valid);
        end

        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (if4.y !== 4'b0000) begin errors++; $display("FAIL async_rst_y got %b want 0000", if4.y); end
        if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_ov got %b want 0", if4.out_valid); end
        if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ir got %b want 1", if4.in_ready); end

        step();
        rst = 1'b0;
        if4.mode = 1'b1; if4.e = 1'b1; if4.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (if4.y !== 4'b0001 || if4.out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_idx0 got y=%b ov=%b want y=0001 ov=1", if4.y, if4.out_valid);
        end
    endtask

    task automatic test_direct_sweep();
        logic [3:0] want;
        do_reset();
        if4.e = 1'b1; if4.out_ready = 1'b1; if4.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if4.s = 2'(i);
            step();
            want = 4'b0001 << i;
            checks++;
            if (if4.y !== want || if4.out_valid !== 1'b1) begin
                errors++; $display("FAIL sweep_s%0d got y=%b ov=%b want y=%b ov=1", i, if4.y, if4.out_valid, want);
            end
        end
        if4.e = 1'b0; if4.s = 2'd3;
        step();
        checks++;
        if (if4.y !== 4'b0000 || if4.out_valid !== 1'b1) begin
            errors++; $display("FAIL sweep_e0 got y=%b ov=%b want y=0000 ov=1", if4.y, if4.out_valid);
        end
        if4.in_valid = 1'b0;
        step();
        checks++;
        if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain got ov=%b want 0", if4.out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        if4.e = 1'b1; if4.out_ready = 1'b1; if4.in_valid = 1'b1; if4.s = 2'd1;
        step();
        if4.out_ready = 1'b0; if4.s = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ir_%0d got %b want 0", i, if4.in_ready); end
            step();
            checks++;
            if (if4.y !== 4'b0010 || if4.out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_%0d got y=%b ov=%b want y=0010 ov=1", i, if4.y, if4.out_valid);
            end
        end
        if4.out_ready = 1'b1; if4.s = 2'd3;
        #1;
        checks++;
        if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ir got %b want 1", if4.in_ready); end
        step();
        checks++;
        if (if4.y !== 4'b1000 || if4.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_no_bubble got y=%b ov=%b want y=1000 ov=1", if4.y, if4.out_valid);
        end
        if4.in_valid = 1'b0;
        step();
    endtask

    task automatic test_scan_wrap();
        logic [5:0] want;
        do_reset();
        if6.mode = 1'b1; if6.e = 1'b1; if6.out_ready = 1'b1;
        step();
        checks++;
        if (if6.out_valid !== 1'b0) begin errors++; $display("FAIL scan_first_lat got ov=%b want 0", if6.out_valid); end
        for (int i = 0; i < 8; i++) begin
            step();
            want = 6'b000001 << (i % 6);
            checks++;
            if (if6.y !== want || if6.out_valid !== 1'b1) begin
                errors++; $display("FAIL scan_walk_%0d got y=%b ov=%b want y=%b ov=1", i, if6.y, if6.out_valid, want);
            end
        end
        if6.e = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (if6.out_valid !== 1'b0) begin errors++; $display("FAIL scan_pause_%0d got ov=%b want 0", i, if6.out_valid); end
        end
        if6.e = 1'b1;
        step();
        checks++;
        if (if6.y !== 6'b000100 || if6.out_valid !== 1'b1) begin
            errors++; $display("FAIL scan_resume got y=%b ov=%b want y=000100 ov=1", if6.y, if6.out_valid);
        end
    endtask

    task automatic test_mode_switch();
        // Continues from the resumed scan: 000100 is on y.
        if6.out_ready = 1'b0; if6.mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if6.y !== 6'b000100 || if6.out_valid !== 1'b1 || if6.in_ready !== 1'b0) begin
                errors++; $display("FAIL mode_stall_%0d got y=%b ov=%b ir=%b want y=000100 ov=1 ir=0",
                                   i, if6.y, if6.out_valid, if6.in_ready);
            end
        end
        if6.out_ready = 1'b1; if6.e = 1'b0;
        step();
        if6.out_ready = 1'b0;
        #1;
        checks++;
        if (if6.in_ready !== 1'b1 || if6.out_valid !== 1'b0) begin
            errors++; $display("FAIL mode_direct got ir=%b ov=%b want ir=1 ov=0", if6.in_ready, if6.out_valid);
        end
        if6.e = 1'b1; if6.in_valid = 1'b1; if6.s = 3'd1;
        step();
        if6.in_valid = 1'b0;
        checks++;
        if (if6.y !== 6'b000010 || if6.out_valid !== 1'b1) begin
            errors++; $display("FAIL mode_direct_beat got y=%b ov=%b want y=000010 ov=1", if6.y, if6.out_valid);
        end
    endtask

    task automatic test_range_check();
        do_reset();
        if6.e = 1'b1; if6.out_ready = 1'b1; if6.in_valid = 1'b1; if6.s = 3'd7;
        step();
        checks++;
        if (if6.y !== 6'b000000 || if6.err !== RC) begin
            errors++; $display("FAIL range_s7 got y=%b err=%b want y=000000 err=%b", if6.y, if6.err, RC);
        end
        if6.s = 3'd5;
        step();
        checks++;
        if (if6.y !== 6'b100000 || if6.err !== 1'b0) begin
            errors++; $display("FAIL range_s5 got y=%b err=%b want y=100000 err=0", if6.y, if6.err);
        end
        if6.s = 3'd6;
        step();
        if6.in_valid = 1'b0; if6.out_ready = 1'b0;
        step();
        checks++;
        if (if6.y !== 6'b000000 || if6.err !== RC || if6.out_valid !== 1'b1) begin
            errors++; $display("FAIL range_s6_hold got y=%b err=%b ov=%b want y=000000 err=%b ov=1",
                               if6.y, if6.err, if6.out_valid, RC);
        end
    endtask

    // Reference: the output register holds "which line is lit" (-1 for none), the scan
    // pointer walks 0..OUTS-1 cyclically, and mode takes effect only when the register is free.
    task automatic test_random();
        bit         m_scan = 1'b0;
        int         m_idx = 0;
        int         m_line = -1;
        bit         m_ov = 1'b0;
        bit         m_err = 1'b0;
        bit         free;
        int         sel;
        logic [5:0] want;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 7) == 0) if6.mode = ~if6.mode;
            if6.e         = ($urandom_range(0, 3) != 0);
            sel           = int'($urandom_range(0, 7));
            if6.s         = 3'(sel);
            if6.in_valid  = $urandom_range(0, 1) == 1;
            if6.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            free = !m_ov || if6.out_ready;
            checks++;
            if (if6.in_ready !== (!m_scan && free)) begin
                errors++; $display("FAIL rnd_ir cyc%0d got %b want %b", cyc, if6.in_ready, !m_scan && free);
            end

            if (free) begin
                if (m_scan && if6.e) begin
                    m_line = m_idx; m_ov = 1'b1; m_err = 1'b0; m_idx = (m_idx + 1) % 6;
                end else if (!m_scan && if6.in_valid) begin
                    m_line = (if6.e && sel < 6) ? sel : -1; m_ov = 1'b1; m_err = RC && (sel >= 6);
                end else begin
                    m_ov = 1'b0;
                end
                m_scan = if6.mode;
            end

            step();
            want = (m_line >= 0) ? 6'(1 << m_line) : 6'b0;
            checks++;
            if (if6.out_valid !== m_ov || if6.err !== m_err || (m_ov && if6.y !== want)) begin
                errors++; $display("FAIL rnd_out cyc%0d got y=%b ov=%b err=%b want y=%b ov=%b err=%b",
                                   cyc, if6.y, if6.out_valid, if6.err, want, m_ov, m_err);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_direct_sweep();
        test_backpressure();
        test_scan_wrap();
        test_mode_switch();
        test_range_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
